mem_stage: RTL



---
 rtl/mem_stage.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
//
// MEM pipeline stage. It reads and writes a 4-line, 16-byte-per-line,
// direct-mapped data array using the dTLB/dCache hit flags resolved in LU.
// Load misses and all stores go through one outstanding memory handshake.
// While that handshake is in flight the stage stalls the upstream LU-MEM bank.
// Results reach the ROB through a registered write-back port.
//
// Ports
//   clk, reset            clock; synchronous active-high reset
//   instruction_MEM       instruction in MEM (opcode [31:26], all-zero = bubble)
//   paddr_MEM             physical address
//   ALU_out_MEM           ALU result, written back for non-memory ops
//   rs_bus_MEM            store data
//   tag_MEM               ROB tag
//   hit_dTLB_MEM          dTLB hit flag from LU
//   hit_dCache_MEM        dCache hit flag from LU
//   stall                 combinational; the LU-MEM bank must not load
//   mem_req/we/addr/wdata/be   registered memory request, held until mem_ack
//   mem_ack, mem_rdata    one-cycle completion pulse and 128-bit fill line
//   fill_valid/index/tag  one-cycle line-installed notification to LU
//   wb_valid/tag/data/exception/exc_code   registered ROB write-back
// -----------------------------------------------------------------------------
module mem_stage #(
    parameter int INSTRUCTION_WIDTH   = 32,
    parameter int DATA_SIZE           = 32,
    parameter int PHYSICAL_ADDR_WIDTH = 20,
    parameter int ROB_WIDTH           = 3
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [INSTRUCTION_WIDTH-1:0]     instruction_MEM,
    input  logic [PHYSICAL_ADDR_WIDTH-1:0]   paddr_MEM,
    input  logic [DATA_SIZE-1:0]             ALU_out_MEM,
    input  logic [DATA_SIZE-1:0]             rs_bus_MEM,
    input  logic [ROB_WIDTH-1:0]             tag_MEM,
    input  logic                             hit_dTLB_MEM,
    input  logic                             hit_dCache_MEM,
    output logic                             stall,
    output logic                             mem_req,
    output logic                             mem_we,
    output logic [PHYSICAL_ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_SIZE-1:0]             mem_wdata,
    output logic [3:0]                       mem_be,
    input  logic                             mem_ack,
    input  logic [127:0]                     mem_rdata,
    output logic                             fill_valid,
    output logic [1:0]                       fill_index,
    output logic [PHYSICAL_ADDR_WIDTH-7:0]   fill_tag,
    output logic                             wb_valid,
    output logic [ROB_WIDTH-1:0]             wb_tag,
    output logic [DATA_SIZE-1:0]             wb_data,
    output logic                             wb_exception,
    output logic [1:0]                       wb_exc_code
);

    localparam logic [5:0] OP_LW = 6'h23;
    localparam logic [5:0] OP_LB = 6'h20;
    localparam logic [5:0] OP_SW = 6'h2B;
    localparam logic [5:0] OP_SB = 6'h28;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_WRITE
    } state_t;

    state_t state_q, state_d;

    // Selects the loaded value from a word: LB sign-extends one byte, LW takes the word.
    function automatic logic [DATA_SIZE-1:0] load_value(input logic [DATA_SIZE-1:0] word,
                                                        input logic [1:0] bsel,
                                                        input logic is_byte);
        logic signed [7:0] b;
        b = word[{bsel, 3'b000} +: 8];
        if (is_byte) load_value = {{(DATA_SIZE-8){b[7]}}, b};
        else         load_value = word;
    endfunction

    // Decode of the instruction currently held in MEM
    logic [5:0] opcode;
    logic       is_bubble, is_lw, is_lb, is_sw, is_sb, is_load, is_store, is_mem;
    logic       misaligned, exc_tlb, exc_align, need_mem;
    logic [DATA_SIZE-1:0] hit_word;

    assign opcode     = instruction_MEM[INSTRUCTION_WIDTH-1 -: 6];
    assign is_bubble  = (instruction_MEM == '0);
    assign is_lw      = (opcode == OP_LW);
    assign is_lb      = (opcode == OP_LB);
    assign is_sw      = (opcode == OP_SW);
    assign is_sb      = (opcode == OP_SB);
    assign is_load    = is_lw | is_lb;
    assign is_store   = is_sw | is_sb;
    assign is_mem     = is_load | is_store;
    assign misaligned = (is_lw | is_sw) & (paddr_MEM[1:0] != 2'b00);
    // TLB miss takes priority over the alignment fault.
    assign exc_tlb    = is_mem & ~hit_dTLB_MEM;
    assign exc_align  = is_mem & hit_dTLB_MEM & misaligned;
    assign need_mem   = is_mem & hit_dTLB_MEM & ~misaligned & (is_store | ~hit_dCache_MEM);

    // Data array and latched copy of the outstanding memory operation
    logic [127:0]                   line_q [4];
    logic [ROB_WIDTH-1:0]           op_tag_q;
    logic [1:0]                     op_index_q, op_word_q, op_byte_q;
    logic                           op_lb_q, op_store_hit_q;
    logic [PHYSICAL_ADDR_WIDTH-7:0] op_ltag_q;

    assign hit_word = line_q[paddr_MEM[5:4]][{paddr_MEM[3:2], 5'b00000} +: DATA_SIZE];

    // Registered outputs
    logic                           mem_req_q, mem_we_q, fill_valid_q;
    logic [PHYSICAL_ADDR_WIDTH-1:0] mem_addr_q;
    logic [DATA_SIZE-1:0]           mem_wdata_q, wb_data_q;
    logic [3:0]                     mem_be_q;
    logic [1:0]                     fill_index_q, wb_exc_code_q;
    logic [PHYSICAL_ADDR_WIDTH-7:0] fill_tag_q;
    logic                           wb_valid_q, wb_exception_q;
    logic [ROB_WIDTH-1:0]           wb_tag_q;

    // The ack cycle drops stall so the bank advances at the same edge the
    // outstanding op retires.
    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        case (state_q)
            S_IDLE: begin
                stall = need_mem;
                if (need_mem) state_d = is_store ? S_WRITE : S_FILL;
            end
            S_FILL, S_WRITE: begin
                stall = ~mem_ack;
                if (mem_ack) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            for (int i = 0; i < 4; i++) line_q[i] <= '0;
            op_tag_q       <= '0;
            op_index_q     <= '0;
            op_word_q      <= '0;
            op_byte_q      <= '0;
            op_lb_q        <= 1'b0;
            op_store_hit_q <= 1'b0;
            op_ltag_q      <= '0;
            mem_req_q      <= 1'b0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
            mem_be_q       <= '0;
            fill_valid_q   <= 1'b0;
            fill_index_q   <= '0;
            fill_tag_q     <= '0;
            wb_valid_q     <= 1'b0;
            wb_tag_q       <= '0;
            wb_data_q      <= '0;
            wb_exception_q <= 1'b0;
            wb_exc_code_q  <= '0;
        end else begin
            state_q      <= state_d;
            wb_valid_q   <= 1'b0;
            fill_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (need_mem) begin
                        op_tag_q       <= tag_MEM;
                        op_index_q     <= paddr_MEM[5:4];
                        op_word_q      <= paddr_MEM[3:2];
                        op_byte_q      <= paddr_MEM[1:0];
                        op_lb_q        <= is_lb;
                        op_store_hit_q <= hit_dCache_MEM;
                        op_ltag_q      <= paddr_MEM[PHYSICAL_ADDR_WIDTH-1:6];
                        mem_req_q      <= 1'b1;
                        mem_we_q       <= is_store;
                        if (is_store) begin
                            mem_addr_q  <= paddr_MEM;
                            mem_wdata_q <= is_sw ? rs_bus_MEM : {(DATA_SIZE/8){rs_bus_MEM[7:0]}};
                            mem_be_q    <= is_sw ? 4'b1111 : (4'b0001 << paddr_MEM[1:0]);
                        end else begin
                            mem_addr_q  <= {paddr_MEM[PHYSICAL_ADDR_WIDTH-1:4], 4'b0000};
                            mem_wdata_q <= '0;
                            mem_be_q    <= '0;
                        end
                    end else if (!is_bubble) begin
                        wb_valid_q     <= 1'b1;
                        wb_tag_q       <= tag_MEM;
                        wb_exception_q <= exc_tlb | exc_align;
                        wb_exc_code_q  <= exc_tlb ? 2'd1 : (exc_align ? 2'd2 : 2'd0);
                        if (exc_tlb | exc_align) wb_data_q <= '0;
                        else if (is_load)        wb_data_q <= load_value(hit_word, paddr_MEM[1:0], is_lb);
                        else                     wb_data_q <= ALU_out_MEM;
                    end
                end
                S_FILL, S_WRITE: begin
                    if (mem_ack) begin
                        mem_req_q      <= 1'b0;
                        mem_we_q       <= 1'b0;
                        mem_addr_q     <= '0;
                        mem_wdata_q    <= '0;
                        mem_be_q       <= '0;
                        wb_valid_q     <= 1'b1;
                        wb_tag_q       <= op_tag_q;
                        wb_exception_q <= 1'b0;
                        wb_exc_code_q  <= 2'd0;
                        if (state_q == S_FILL) begin
                            line_q[op_index_q] <= mem_rdata;
                            fill_valid_q       <= 1'b1;
                            fill_index_q       <= op_index_q;
                            fill_tag_q         <= op_ltag_q;
                            wb_data_q          <= load_value(mem_rdata[{op_word_q, 5'b00000} +: DATA_SIZE],
                                                             op_byte_q, op_lb_q);
                        end else begin
                            // Write-through, no-allocate: only a hit line is updated.
                            if (op_store_hit_q) begin
                                for (int b = 0; b < 4; b++) begin
                                    if (mem_be_q[b])
                                        line_q[op_index_q][{op_word_q, 2'(b), 3'b000} +: 8] <= mem_wdata_q[8*b +: 8];
                                end
                            end
                            wb_data_q <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_req      = mem_req_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign mem_be       = mem_be_q;
    assign fill_valid   = fill_valid_q;
    assign fill_index   = fill_index_q;
    assign fill_tag     = fill_tag_q;
    assign wb_valid     = wb_valid_q;
    assign wb_tag       = wb_tag_q;
    assign wb_data      = wb_data_q;
    assign wb_exception = wb_exception_q;
    assign wb_exc_code  = wb_exc_code_q;

endmodule
